cv32e40p_x_offload_tracker: RTL

//   Core-side scheduler for CORE-V-XIF offloaded instructions. Allocates issue IDs and gates
//   x_issue_valid on free-ID and register-hazard checks. Sequences the commit transaction and

---
 rtl/cv32e40p_core_v_xif_pkg.sv | 16 +
 rtl/cv32e40p_ff_one.sv | 21 ++
 rtl/cv32e40p_x_offload_tracker.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cv32e40p_core_v_xif_pkg.sv
// rtl/cv32e40p_core_v_xif_pkg.sv - CORE-V-XIF offload tracker entry types
package cv32e40p_core_v_xif_pkg;

  typedef enum logic [1:0] {
    X_FREE      = 2'd0,
    X_ISSUED    = 2'd1,
    X_COMMITTED = 2'd2
  } x_entry_state_e;

  typedef struct packed {
    x_entry_state_e state;
    logic [4:0]     rd;
    logic           writeback;
  } x_entry_t;

endpackage

// File: rtl/cv32e40p_ff_one.sv
// rtl/cv32e40p_ff_one.sv - index of the lowest set bit of a vector
module cv32e40p_ff_one #(
  parameter int LEN = 16
) (
  input  logic [LEN-1:0]         vec,
  output logic [$clog2(LEN)-1:0] first_one,
  output logic                   no_ones
);

  localparam int W = $clog2(LEN);

  always_comb begin
    first_one = '0;
    for (int k = LEN - 1; k >= 0; k--) begin
      if (vec[k]) first_one = W'(k);
    end
  end

  assign no_ones = ~|vec;

endmodule

// File: rtl/cv32e40p_x_offload_tracker.sv
// rtl/cv32e40p_x_offload_tracker.sv - XIF issue ID allocation, commit sequencing and result writeback
module cv32e40p_x_offload_tracker
  import cv32e40p_core_v_xif_pkg::*;
#(
  parameter int X_ID_WIDTH = 4,
  parameter int X_NUM_RS   = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         offload_valid_i,
  input  logic [X_NUM_RS-1:0][4:0]     offload_rs_i,
  input  logic [4:0]                   offload_rd_i,
  input  logic                         offload_kill_i,
  output logic                         offload_stall_o,
  output logic                         x_issue_valid_o,
  output logic [X_ID_WIDTH-1:0]        x_issue_id_o,
  input  logic                         x_issue_ready_i,
  input  logic                         x_issue_accept_i,
  input  logic                         x_issue_writeback_i,
  output logic                         x_commit_valid_o,
  output logic [X_ID_WIDTH-1:0]        x_commit_id_o,
  output logic                         x_commit_kill_o,
  input  logic                         x_result_valid_i,
  output logic                         x_result_ready_o,
  input  logic [X_ID_WIDTH-1:0]        x_result_id_i,
  input  logic [4:0]                   x_result_rd_i,
  input  logic                         x_result_we_i,
  input  logic [31:0]                  x_result_data_i,
  input  logic                         wb_port_free_i,
  output logic                         rf_we_o,
  output logic [4:0]                   rf_waddr_o,
  output logic [31:0]                  rf_wdata_o,
  output logic                         protocol_err_o
);

  localparam int NID = 2 ** X_ID_WIDTH;

  x_entry_t              entries_q [NID];
  x_entry_t              entries_d [NID];
  logic [31:0]           scoreboard_q, scoreboard_d;
  logic                  commit_valid_q;
  logic [X_ID_WIDTH-1:0] commit_id_q;
  logic [NID-1:0]        free_vec;
  logic                  no_free, hazard, issue_accept;
  x_entry_t              res_entry, commit_entry;
  logic                  res_committed, result_retire, result_stray;

  always_comb begin
    for (int i = 0; i < NID; i++) free_vec[i] = (entries_q[i].state == X_FREE);
  end

  cv32e40p_ff_one #(.LEN(NID)) u_free_search (
    .vec       (free_vec),
    .first_one (x_issue_id_o),
    .no_ones   (no_free)
  );

  // x0 is never tracked, so it can never raise a hazard
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < X_NUM_RS; k++) begin
      if (offload_rs_i[k] != 5'd0 && scoreboard_q[offload_rs_i[k]]) hazard = 1'b1;
    end
    if (offload_rd_i != 5'd0 && scoreboard_q[offload_rd_i]) hazard = 1'b1;
  end

  assign x_issue_valid_o = offload_valid_i & ~no_free & ~hazard;
  assign offload_stall_o = offload_valid_i & (no_free | hazard | ~x_issue_ready_i);
  assign issue_accept    = x_issue_valid_o & x_issue_ready_i & x_issue_accept_i;

  assign x_commit_valid_o = commit_valid_q;
  assign x_commit_id_o    = commit_id_q;
  assign x_commit_kill_o  = commit_valid_q & offload_kill_i;
  assign commit_entry     = entries_q[commit_id_q];

  // Stray results are swallowed so a misbehaving coprocessor cannot wedge the port
  assign res_entry        = entries_q[x_result_id_i];
  assign res_committed    = (res_entry.state == X_COMMITTED);
  assign x_result_ready_o = res_committed ? wb_port_free_i : x_result_valid_i;
  assign result_retire    = x_result_valid_i & res_committed & wb_port_free_i;
  assign result_stray     = x_result_valid_i & ~res_committed;

  // Clears are applied before the issue set so that a set on the same rd wins
  always_comb begin
    entries_d    = entries_q;
    scoreboard_d = scoreboard_q;
    if (result_retire) begin
      entries_d[x_result_id_i].state = X_FREE;
      if (res_entry.writeback) scoreboard_d[res_entry.rd] = 1'b0;
    end
    if (commit_valid_q) begin
      if (offload_kill_i) begin
        entries_d[commit_id_q].state = X_FREE;
        if (commit_entry.writeback) scoreboard_d[commit_entry.rd] = 1'b0;
      end else begin
        entries_d[commit_id_q].state = X_COMMITTED;
      end
    end
    if (issue_accept) begin
      entries_d[x_issue_id_o] = '{state: X_ISSUED, rd: offload_rd_i, writeback: x_issue_writeback_i};
      if (x_issue_writeback_i && offload_rd_i != 5'd0) scoreboard_d[offload_rd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NID; i++) entries_q[i] <= '0;
      scoreboard_q   <= '0;
      commit_valid_q <= 1'b0;
      commit_id_q    <= '0;
      rf_we_o        <= 1'b0;
      rf_waddr_o     <= '0;
      rf_wdata_o     <= '0;
      protocol_err_o <= 1'b0;
    end else begin
      for (int i = 0; i < NID; i++) entries_q[i] <= entries_d[i];
      scoreboard_q   <= scoreboard_d;
      commit_valid_q <= issue_accept;
      commit_id_q    <= x_issue_id_o;
      rf_we_o        <= result_retire & x_result_we_i & (x_result_rd_i != 5'd0);
      if (result_retire) begin
        rf_waddr_o <= x_result_rd_i;
        rf_wdata_o <= x_result_data_i;
      end
      if (result_stray) protocol_err_o <= 1'b1;
    end
  end

endmodule
